// File: rtl/uart_tx_arbitro_if.sv
// uart_tx_arbitro_if
// Bundles the producer push ports, the transmitter handshake and the status
// flags of the transmit scheduler.
//   slave  : scheduler side (consumes pushes and uart_pronto, drives the rest)
//   master : producer/transmitter side (the mirror image)
// Signals:
//   escreve_a/b, dado_a/b : per-channel push strobe and byte
//   uart_pronto           : end-of-frame pulse from the transmitter
//   uart_partida          : start pulse to the transmitter
//   uart_dados            : byte presented to the transmitter (registered)
//   cheio_a/b, vazio_a/b  : FIFO full / empty flags
//   enviado_a/b           : one-cycle pulse when a channel's byte completed
//   ocupado, db_estado    : busy flag and current FSM state code
`timescale 1ns/1ps
interface uart_tx_arbitro_if;
  logic       escreve_a;
  logic [7:0] dado_a;
  logic       escreve_b;
  logic [7:0] dado_b;
  logic       uart_pronto;
  logic       uart_partida;
  logic [7:0] uart_dados;
  logic       cheio_a;
  logic       cheio_b;
  logic       vazio_a;
  logic       vazio_b;
  logic       enviado_a;
  logic       enviado_b;
  logic       ocupado;
  logic [3:0] db_estado;

  modport slave (
    input  escreve_a, dado_a, escreve_b, dado_b, uart_pronto,
    output uart_partida, uart_dados, cheio_a, cheio_b, vazio_a, vazio_b,
           enviado_a, enviado_b, ocupado, db_estado
  );

  modport master (
    output escreve_a, dado_a, escreve_b, dado_b, uart_pronto,
    input  uart_partida, uart_dados, cheio_a, cheio_b, vazio_a, vazio_b,
           enviado_a, enviado_b, ocupado, db_estado
  );
endinterface

// File: rtl/uart_tx_arbitro.sv
// uart_tx_arbitro
// Transmit scheduler in front of an 8N1 UART transmitter. Two producers
// (channel A = index 0, channel B = index 1) push bytes into private circular
// FIFOs; a round-robin grant picks the next channel and the FSM walks each
// byte through the transmitter's partida/pronto handshake.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low; flushes both FIFOs, FSM back to OCIOSO
//   bus   : uart_tx_arbitro_if.slave (pushes, handshake, status flags)
`timescale 1ns/1ps
module uart_tx_arbitro #(
  parameter int DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbitro_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [3:0] OCIOSO  = 4'd0;
  localparam logic [3:0] CARREGA = 4'd1;
  localparam logic [3:0] PARTIDA = 4'd2;
  localparam logic [3:0] ESPERA  = 4'd3;
  localparam logic [3:0] FIM     = 4'd4;

  logic [7:0]    mem_q [2][DEPTH];
  logic [PW-1:0] wr_q  [2];
  logic [PW-1:0] wr_d  [2];
  logic [PW-1:0] rd_q  [2];
  logic [PW-1:0] rd_d  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [7:0]    wdata [2];
  logic [1:0]    escreve, push, pop, cheio, vazio;

  logic [3:0] estado_q, estado_d;
  logic       canal_q, canal_d;
  logic       ultimo_q, ultimo_d;
  logic       grant;
  logic [7:0] dados_q, dados_d;

  assign escreve  = {bus.escreve_b, bus.escreve_a};
  assign wdata[0] = bus.dado_a;
  assign wdata[1] = bus.dado_b;

  // Flags come straight from the registered count; a push into a full FIFO
  // is dropped even when the same FIFO is popped in that cycle.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cheio[c] = (cnt_q[c] == CW'(DEPTH));
      vazio[c] = (cnt_q[c] == '0);
      push[c]  = escreve[c] & ~cheio[c];
    end
  end

  // Only the FSM pops, and only from the channel it latched while idle.
  assign pop[0] = (estado_q == CARREGA) && !canal_q;
  assign pop[1] = (estado_q == CARREGA) &&  canal_q;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_d[c]  = wr_q[c];
      rd_d[c]  = rd_q[c];
      cnt_d[c] = cnt_q[c];
      if (push[c]) wr_d[c] = wr_q[c] + PW'(1);
      if (pop[c])  rd_d[c] = rd_q[c] + PW'(1);
      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_q[c]  <= wr_d[c];
        rd_q[c]  <= rd_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Storage carries no reset; a flushed FIFO is empty by its count alone.
  always_ff @(posedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_q[c]] <= wdata[c];
    end
  end

  // Both pending: serve the channel not served last. One pending: serve it.
  assign grant = (!vazio[0] && !vazio[1]) ? ~ultimo_q : vazio[0];

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  // FSM next state; unused codes fall back to OCIOSO
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (vazio != 2'b11) estado_d = CARREGA;
      CARREGA: estado_d = PARTIDA;
      PARTIDA: estado_d = ESPERA;
      ESPERA:  if (bus.uart_pronto) estado_d = FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Grant is re-latched every idle cycle, so the value held on leaving
  // OCIOSO is the one for the byte about to be sent.
  always_comb begin
    canal_d  = canal_q;
    ultimo_d = ultimo_q;
    dados_d  = dados_q;
    if (estado_q == OCIOSO)  canal_d  = grant;
    if (estado_q == CARREGA) dados_d  = mem_q[canal_q][rd_q[canal_q]];
    if (estado_q == FIM)     ultimo_d = canal_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      canal_q  <= 1'b0;
      ultimo_q <= 1'b1;
      dados_q  <= 8'h00;
    end else begin
      canal_q  <= canal_d;
      ultimo_q <= ultimo_d;
      dados_q  <= dados_d;
    end
  end

  // FSM outputs
  always_comb begin
    bus.uart_partida = (estado_q == PARTIDA);
    bus.enviado_a    = (estado_q == FIM) && !canal_q;
    bus.enviado_b    = (estado_q == FIM) &&  canal_q;
    bus.ocupado      = (estado_q != OCIOSO);
  end

  assign bus.db_estado  = estado_q;
  assign bus.uart_dados = dados_q;
  assign bus.cheio_a    = cheio[0];
  assign bus.cheio_b    = cheio[1];
  assign bus.vazio_a    = vazio[0];
  assign bus.vazio_b    = vazio[1];
endmodule

// File: tb/tb_uart_tx_arbitro.sv
`timescale 1ns/1ps
module tb_uart_tx_arbitro;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_tx_arbitro_if bus();

  uart_tx_arbitro #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic       stall         = 1'b0;
  logic       pronto_stub   = 1'b0;
  logic       pronto_manual = 1'b0;
  logic       stub_busy     = 1'b0;
  int         delay         = 9;
  logic [7:0] sent[$];
  int         en_a = 0;
  int         en_b = 0;

  assign bus.uart_pronto = pronto_stub | pronto_manual;

  // Transmitter stub: captures each started byte, answers with pronto after
  // `delay` cycles unless stalled, and watches uart_dados stay put meanwhile.
  initial begin : stub
    int cnt;
    logic [7:0] held;
    cnt  = 0;
    held = 8'h00;
    forever begin
      @(negedge clock);
      pronto_stub = 1'b0;
      if (!reset) begin
        stub_busy = 1'b0;
      end else if (stub_busy) begin
        checks++;
        if (bus.uart_dados !== held) begin
          errors++;
          $display("FAIL dados_stable got %h expected %h", bus.uart_dados, held);
        end
        if (!stall) begin
          if (cnt == 0) begin
            pronto_stub = 1'b1;
            stub_busy   = 1'b0;
          end else begin
            cnt--;
          end
        end
      end else if (bus.uart_partida === 1'b1) begin
        sent.push_back(bus.uart_dados);
        held      = bus.uart_dados;
        stub_busy = 1'b1;
        cnt       = delay;
      end
    end
  end

  initial begin : enviado_mon
    forever begin
      @(negedge clock);
      if (bus.enviado_a === 1'b1) en_a++;
      if (bus.enviado_b === 1'b1) en_b++;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset         = 1'b1;
    stall         = 1'b0;
    pronto_manual = 1'b0;
    delay         = 9;
    sent.delete();
    en_a = 0;
    en_b = 0;
  endtask

  // Drives one push for one cycle; returns at the negedge after the push edge.
  task automatic push1(input bit ch, input logic [7:0] d);
    @(negedge clock);
    if (ch == 1'b0) begin bus.escreve_a = 1'b1; bus.dado_a = d; end
    else            begin bus.escreve_b = 1'b1; bus.dado_b = d; end
    @(negedge clock);
    bus.escreve_a = 1'b0;
    bus.escreve_b = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    int n = 0;
    while (bus.db_estado !== s && n < 500) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s timeout waiting state got %0d expected %0d", name, bus.db_estado, s);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bus.ocupado === 1'b0 && bus.vazio_a === 1'b1 && bus.vazio_b === 1'b1 && !stub_busy)
           && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s timeout waiting idle estado %0d", name, bus.db_estado);
    end
  endtask

  task automatic check_sent(input string name, input logic [7:0] expq[$]);
    checks++;
    if (sent.size() != expq.size()) begin
      errors++;
      $display("FAIL %s_count got %0d bytes expected %0d", name, sent.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < sent.size(); i++) begin
      checks++;
      if (sent[i] !== expq[i]) begin
        errors++;
        $display("FAIL %s_byte%0d got %h expected %h", name, i, sent[i], expq[i]);
      end
    end
  endtask

  task automatic check_en(input string name, input int ea, input int eb);
    checks++;
    if (en_a != ea || en_b != eb) begin
      errors++;
      $display("FAIL %s_enviado got a=%0d b=%0d expected a=%0d b=%0d", name, en_a, en_b, ea, eb);
    end
  endtask

  task automatic test_reset();
    logic [7:0] e[$];
    do_reset();
    checks++;
    if (bus.db_estado !== 4'd0 || bus.vazio_a !== 1'b1 || bus.vazio_b !== 1'b1 ||
        bus.cheio_a !== 1'b0 || bus.cheio_b !== 1'b0 || bus.uart_partida !== 1'b0 ||
        bus.uart_dados !== 8'h00 || bus.ocupado !== 1'b0 ||
        bus.enviado_a !== 1'b0 || bus.enviado_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got estado=%0d vazio=%b%b cheio=%b%b dados=%h ocupado=%b",
               bus.db_estado, bus.vazio_a, bus.vazio_b, bus.cheio_a, bus.cheio_b,
               bus.uart_dados, bus.ocupado);
    end
    stall = 1'b1;
    push1(1'b0, 8'h5A);
    push1(1'b0, 8'hA5);
    wait_state(4'd3, "reset_espera");
    checks++;
    if (bus.vazio_a !== 1'b0 || bus.uart_dados !== 8'h5A) begin
      errors++;
      $display("FAIL reset_pre got vazio_a=%b dados=%h expected 0 5a", bus.vazio_a, bus.uart_dados);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.db_estado !== 4'd0 || bus.vazio_a !== 1'b1 || bus.vazio_b !== 1'b1 ||
        bus.cheio_a !== 1'b0 || bus.cheio_b !== 1'b0 || bus.uart_partida !== 1'b0 ||
        bus.uart_dados !== 8'h00 || bus.ocupado !== 1'b0 ||
        bus.enviado_a !== 1'b0 || bus.enviado_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got estado=%0d vazio=%b%b dados=%h ocupado=%b expected 0 11 00 0",
               bus.db_estado, bus.vazio_a, bus.vazio_b, bus.uart_dados, bus.ocupado);
    end
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (bus.db_estado !== 4'd0 || bus.vazio_a !== 1'b1 || bus.vazio_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_after got estado=%0d vazio=%b%b expected 0 11",
               bus.db_estado, bus.vazio_a, bus.vazio_b);
    end
    e = '{8'h5A};
    check_sent("reset_sent", e);
    check_en("reset", 0, 0);
  endtask

  task automatic test_single();
    logic [7:0] e[$];
    do_reset();
    push1(1'b0, 8'h41);
    checks++;
    if (bus.db_estado !== 4'd0 || bus.vazio_a !== 1'b0) begin
      errors++;
      $display("FAIL single_t0 got estado=%0d vazio_a=%b expected 0 0", bus.db_estado, bus.vazio_a);
    end
    @(negedge clock);
    checks++;
    if (bus.db_estado !== 4'd1 || bus.uart_partida !== 1'b0) begin
      errors++;
      $display("FAIL single_t1 got estado=%0d partida=%b expected 1 0", bus.db_estado, bus.uart_partida);
    end
    @(negedge clock);
    checks++;
    if (bus.uart_partida !== 1'b1 || bus.uart_dados !== 8'h41 || bus.db_estado !== 4'd2) begin
      errors++;
      $display("FAIL single_t2 got partida=%b dados=%h estado=%0d expected 1 41 2",
               bus.uart_partida, bus.uart_dados, bus.db_estado);
    end
    @(negedge clock);
    checks++;
    if (bus.uart_partida !== 1'b0 || bus.db_estado !== 4'd3) begin
      errors++;
      $display("FAIL single_t3 got partida=%b estado=%0d expected 0 3", bus.uart_partida, bus.db_estado);
    end
    wait_idle("single");
    e = '{8'h41};
    check_sent("single_sent", e);
    check_en("single", 1, 0);
  endtask

  task automatic test_round_robin();
    logic [7:0] e[$];
    do_reset();
    @(negedge clock);
    bus.escreve_a = 1'b1; bus.dado_a = 8'h31;
    bus.escreve_b = 1'b1; bus.dado_b = 8'h61;
    @(negedge clock);
    bus.dado_a = 8'h32;
    bus.dado_b = 8'h62;
    @(negedge clock);
    bus.escreve_a = 1'b0;
    bus.escreve_b = 1'b0;
    wait_idle("rr");
    e = '{8'h31, 8'h61, 8'h32, 8'h62};
    check_sent("rr_sent", e);
    check_en("rr", 2, 2);
  endtask

  task automatic test_full();
    logic [7:0] e[$];
    do_reset();
    stall = 1'b1;
    push1(1'b0, 8'h11);
    wait_state(4'd3, "full_espera");
    for (int i = 0; i < 5; i++) begin
      push1(1'b1, 8'hB0 + 8'(i));
      checks++;
      if (bus.cheio_b !== (i >= 3)) begin
        errors++;
        $display("FAIL full_cheio_after_push%0d got %b expected %b", i + 1, bus.cheio_b, (i >= 3));
      end
    end
    stall = 1'b0;
    wait_idle("full");
    e = '{8'h11, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    check_sent("full_sent", e);
    check_en("full", 1, 4);
  endtask

  task automatic test_push_full_pop();
    logic [7:0] e[$];
    do_reset();
    stall = 1'b1;
    push1(1'b0, 8'h22);
    wait_state(4'd3, "fullpop_espera");
    for (int i = 0; i < 4; i++) push1(1'b1, 8'hC0 + 8'(i));
    checks++;
    if (bus.cheio_b !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_cheio got %b expected 1", bus.cheio_b);
    end
    stall = 1'b0;
    wait_state(4'd1, "fullpop_carrega");
    bus.escreve_b = 1'b1;
    bus.dado_b    = 8'hEE;
    @(negedge clock);
    bus.escreve_b = 1'b0;
    checks++;
    if (bus.cheio_b !== 1'b0 || bus.vazio_b !== 1'b0 || bus.db_estado !== 4'd2) begin
      errors++;
      $display("FAIL fullpop_after got cheio_b=%b vazio_b=%b estado=%0d expected 0 0 2",
               bus.cheio_b, bus.vazio_b, bus.db_estado);
    end
    wait_idle("fullpop");
    e = '{8'h22, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    check_sent("fullpop_sent", e);
    check_en("fullpop", 1, 4);
  endtask

  task automatic test_stray();
    logic [7:0] e[$];
    do_reset();
    @(negedge clock);
    pronto_manual = 1'b1;
    @(negedge clock);
    pronto_manual = 1'b0;
    checks++;
    if (bus.db_estado !== 4'd0 || bus.enviado_a !== 1'b0 || bus.enviado_b !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle got estado=%0d enviado=%b%b expected 0 00",
               bus.db_estado, bus.enviado_a, bus.enviado_b);
    end
    push1(1'b0, 8'h55);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.db_estado !== 4'd2) begin
      errors++;
      $display("FAIL stray_partida_state got %0d expected 2", bus.db_estado);
    end
    pronto_manual = 1'b1;
    @(negedge clock);
    pronto_manual = 1'b0;
    checks++;
    if (bus.db_estado !== 4'd3 || bus.enviado_a !== 1'b0) begin
      errors++;
      $display("FAIL stray_partida got estado=%0d enviado_a=%b expected 3 0",
               bus.db_estado, bus.enviado_a);
    end
    wait_idle("stray");
    e = '{8'h55};
    check_sent("stray_sent", e);
    check_en("stray", 1, 0);
  endtask

  // Reference: FIFOs as queues filled while the transmitter is stalled,
  // then drained by the round-robin rule (alternate when both pending).
  task automatic test_random();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] expq[$];
    int  ea_exp = 0;
    int  eb_exp = 0;
    bit  ultimo_m;
    bit  c0;
    bit  g;
    bit  pa, pb;
    logic [7:0] b, da, db;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      stall = 1'b1;
      delay = int'($urandom_range(1, 6));
      c0 = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      push1(c0, b);
      expq.push_back(b);
      if (c0) eb_exp++; else ea_exp++;
      wait_state(4'd3, "rand_espera");
      for (int k = 0; k < 10; k++) begin
        pa = ($urandom_range(0, 3) != 0);
        pb = ($urandom_range(0, 3) != 0);
        da = 8'($urandom);
        db = 8'($urandom);
        bus.escreve_a = pa; bus.dado_a = da;
        bus.escreve_b = pb; bus.dado_b = db;
        @(negedge clock);
        bus.escreve_a = 1'b0;
        bus.escreve_b = 1'b0;
        if (pa && qa.size() < DEPTH) qa.push_back(da);
        if (pb && qb.size() < DEPTH) qb.push_back(db);
        checks++;
        if (bus.cheio_a !== (qa.size() == DEPTH) || bus.vazio_a !== (qa.size() == 0) ||
            bus.cheio_b !== (qb.size() == DEPTH) || bus.vazio_b !== (qb.size() == 0)) begin
          errors++;
          $display("FAIL rand_flags r%0d k%0d got cheio=%b%b vazio=%b%b expected counts a=%0d b=%0d",
                   r, k, bus.cheio_a, bus.cheio_b, bus.vazio_a, bus.vazio_b, qa.size(), qb.size());
        end
      end
      ultimo_m = c0;
      while (qa.size() > 0 || qb.size() > 0) begin
        if (qa.size() > 0 && qb.size() > 0) g = ~ultimo_m;
        else                                g = (qa.size() == 0);
        if (g) begin expq.push_back(qb.pop_front()); eb_exp++; end
        else   begin expq.push_back(qa.pop_front()); ea_exp++; end
        ultimo_m = g;
      end
      stall = 1'b0;
      wait_idle("rand");
    end
    check_sent("rand_sent", expq);
    check_en("rand", ea_exp, eb_exp);
  endtask

  initial begin
    bus.escreve_a = 1'b0;
    bus.escreve_b = 1'b0;
    bus.dado_a    = 8'h00;
    bus.dado_b    = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_push_full_pop();
    test_stray();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
